ej_sched: RTL and testbench
===========================

Name: ej_sched

Overview:
- Ejection scheduler for an RC ring node.
- Accepts up to two ejected flits per cycle, one from each ring channel ejector output (c_ej0, c_ej1), and buffers each channel in its own FIFO.
- Serialises the flits onto the node's single local ejection port using round-robin arbitration and a valid/ready handshake.
- Drives per-channel ejection-enable back to the ring; a channel whose enable is low must deflect instead of ejecting.

Parameters:
- DEPTH, 4: entries per channel FIFO; power of two, minimum 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- c_ej0  in  `steer_w  channel-0 ejected flit; valid when bit `valid_f is set.
- c_ej1  in  `steer_w  channel-1 ejected flit; same format.
- ej_en0  out  1  channel-0 ejection permitted next cycle (registered).
- ej_en1  out  1  channel-1 ejection permitted next cycle (registered).
- out_flit  out  `steer_w  local ejection flit; all-zero when out_valid=0.
- out_valid  out  1  out_flit holds a flit.
- out_ready  in  1  local sink accepts the flit.
- ovf_err  out  1  sticky flag: a valid flit arrived at a full FIFO.

Behaviour:
- Reset (async assert, sync release)
  - FIFOs empty; ej_en0 = ej_en1 = 1; out_valid = 0; out_flit = 0; ovf_err = 0; RR pointer = channel 0.
- Enqueue
  - FIFO k writes c_ejk when c_ejk[`valid_f] = 1.
  - When FIFO k is full and not popping this cycle: write discarded, ovf_err set; it clears only on reset.
  - Full FIFO popping this cycle: write accepted and count unchanged.
- Ejection enable
  - ej_enk <= (count_next_k <= DEPTH-2), where count_next_k = count_k + push_k - pop_k.
  - Keeps one slot of slack for the flit already in flight during the one-cycle enable lag. ovf_err must never set while the ring honours ej_en.
- Arbitration
  - Output is combinational from the head of the granted FIFO. Latency is 1 cycle: a flit written at edge N is visible on out_flit after edge N.
  - Grant states: IDLE (no grant), G0, G1.
  - IDLE or post-transfer: grant the non-empty channel. If both are non-empty, grant the RR pointer's channel.
  - Grant is locked while out_valid=1 and out_ready=0. out_flit must stay stable and the grant must not change while stalled.
  - Transfer = out_valid & out_ready: pop the granted FIFO and set the RR pointer to the other channel.
  - Same-cycle transfer then re-arbitration: back-to-back output every cycle when flits are available.
- Boundary conditions
  - Both FIFOs empty: out_valid=0, state IDLE.
  - Only one FIFO non-empty: it is granted regardless of the pointer, and the pointer still toggles on transfer.
  - Pointer wrap: PTR_W-bit rd/wr pointers wrap naturally; count is PTR_W+1 bits.
  - Enqueue into an empty FIFO: not visible on the output until the next cycle (no bypass).
  - Reset mid-stall: flits are lost, out_valid drops asynchronously.

Optional Feature:
- Macro: EJ_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat0 and stat1, 16 bits each.
  - Each counts transfers granted from channel 0 and channel 1 respectively, saturating at 16'hFFFF.
  - Also adds stat_ovf (8 bits, saturating) counting discarded writes.
  - All clear on reset.
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

Decomposition:
- Shared defines file: existing `steer_w, `valid_f, `dest_f macros, plus a new `EJ_NCH = 2 constant.
- Sub-module ej_fifo:
  - Single-clock synchronous FIFO with params DEPTH/PTR_W.
  - Ports clk, rst_n, push, din, pop, dout, count, full, empty.
  - Instantiated twice.
- Arbiter and enable logic stay in ej_sched.

Test Plan:
- Single flit: c_ej0 valid (dest 3, payload 'hA5) for 1 cycle, out_ready=1 → out_valid=1 with that flit exactly 1 cycle later, then 0; ej_en0 stays 1.
- Simultaneous: c_ej0 = A and c_ej1 = B in the same cycle, out_ready=1, pointer at 0 → output A then B on consecutive cycles; pointer ends at 0.
- Fairness: both channels inject every cycle for 8 cycles with ring honouring ej_en, out_ready=1 → outputs alternate 0,1,0,1,…; no ovf_err.
- Backpressure: out_ready=0, push 3 flits to ch0 (DEPTH=4) → ej_en0=0 after the 3rd push; out_flit is held stable for 10 stall cycles; release gives in-order drain.
- Overflow: ignore ej_en0 and push 5 flits with out_ready=0 → ovf_err=1 on the 5th; draining yields the first 4 in order.
- Reset mid-stall: assert rst_n=0 with 2 flits queued → out_valid=0 immediately, ej_en=1, and nothing is output after release.

Source files
------------

// File: rtl/ej_sched_pkg.sv
// Shared flit-format macros and types for the ejection scheduler.
// Optional EJ_SCHED_STATS_EN adds transfer/overflow statistics counters.
`ifndef EJ_SCHED_DEFINES
`define EJ_SCHED_DEFINES
`define STEER_W 16
`define VALID_F 15
`define DEST_F 11:8
`define EJ_NCH 2
`endif

package ej_sched_pkg;
   localparam int FLIT_W = `STEER_W;

   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_0    = 2'd1,
      GNT_1    = 2'd2
   } gnt_state_t;
endpackage

// File: rtl/ej_fifo.sv
// Single-clock FIFO holding one ring channel's ejected flits.
// Head is read combinationally; storage is not reset, only pointers/count.
module ej_fifo
   import ej_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [FLIT_W-1:0] din,
   input  logic              pop,
   output logic [FLIT_W-1:0] dout,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              empty
);
   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              wr_en;
   logic              rd_en;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop & ~empty;
   // A full FIFO still accepts a write when its head leaves in the same cycle.
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/ej_sched.sv
// Ejection scheduler: two per-channel FIFOs serialised round-robin onto one port.
// Define EJ_SCHED_STATS_EN to add stat0/stat1/stat_ovf saturating counters.
module ej_sched
   import ej_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [`STEER_W-1:0] c_ej0,
   input  logic [`STEER_W-1:0] c_ej1,
   output logic               ej_en0,
   output logic               ej_en1,
   output logic [`STEER_W-1:0] out_flit,
   output logic               out_valid,
   input  logic               out_ready,
`ifdef EJ_SCHED_STATS_EN
   output logic [15:0]        stat0,
   output logic [15:0]        stat1,
   output logic [7:0]         stat_ovf,
`endif
   output logic               ovf_err
);
   logic [`EJ_NCH-1:0] push;
   logic [`EJ_NCH-1:0] pop;
   logic [`EJ_NCH-1:0] full;
   logic [`EJ_NCH-1:0] empty;
   logic [`EJ_NCH-1:0] ovf_ev;
   logic [FLIT_W-1:0]  head0;
   logic [FLIT_W-1:0]  head1;
   logic [PTR_W:0]     count0;
   logic [PTR_W:0]     count1;
   gnt_state_t         state;
   logic               rr;
   logic               gnt_vld;
   logic               gnt_ch;
   logic               xfer;

   // Enable is granted only if at most DEPTH-2 entries remain after this edge,
   // leaving one slot for a flit already launched during the enable lag.
   function automatic logic en_next(input logic [PTR_W:0] cnt, input logic acc,
                                    input logic pp);
      logic [PTR_W+1:0] cn;
      cn = {1'b0, cnt} + (PTR_W+2)'(acc) - (PTR_W+2)'(pp);
      return (cn <= (PTR_W+2)'(DEPTH - 2));
   endfunction

   assign push = {c_ej1[`VALID_F], c_ej0[`VALID_F]};

   ej_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo0 (
      .clk(clk), .rst_n(rst_n), .push(push[0]), .din(c_ej0), .pop(pop[0]),
      .dout(head0), .count(count0), .full(full[0]), .empty(empty[0])
   );

   ej_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo1 (
      .clk(clk), .rst_n(rst_n), .push(push[1]), .din(c_ej1), .pop(pop[1]),
      .dout(head1), .count(count1), .full(full[1]), .empty(empty[1])
   );

   // A locked state wins; otherwise arbitrate on the FIFOs as they are now.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = 1'b0;
      case (state)
         GNT_0: begin gnt_vld = 1'b1; gnt_ch = 1'b0; end
         GNT_1: begin gnt_vld = 1'b1; gnt_ch = 1'b1; end
         default: begin
            if (!empty[0] && (empty[1] || !rr)) begin
               gnt_vld = 1'b1;
               gnt_ch  = 1'b0;
            end else if (!empty[1]) begin
               gnt_vld = 1'b1;
               gnt_ch  = 1'b1;
            end
         end
      endcase
   end

   assign out_valid = gnt_vld;
   assign out_flit  = gnt_vld ? (gnt_ch ? head1 : head0) : '0;
   assign xfer      = gnt_vld & out_ready;
   assign pop       = xfer ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;
   assign ovf_ev    = push & full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= GNT_IDLE;
         rr      <= 1'b0;
         ej_en0  <= 1'b1;
         ej_en1  <= 1'b1;
         ovf_err <= 1'b0;
      end else begin
         if (gnt_vld && !out_ready) state <= gnt_ch ? GNT_1 : GNT_0;
         else                       state <= GNT_IDLE;
         if (xfer) rr <= ~gnt_ch;
         ej_en0 <= en_next(count0, push[0] & (~full[0] | pop[0]), pop[0]);
         ej_en1 <= en_next(count1, push[1] & (~full[1] | pop[1]), pop[1]);
         if (|ovf_ev) ovf_err <= 1'b1;
      end
   end

`ifdef EJ_SCHED_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] d);
      logic [8:0] s;
      s = {1'b0, v} + {7'd0, d};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat0    <= '0;
         stat1    <= '0;
         stat_ovf <= '0;
      end else begin
         if (pop[0]) stat0 <= sat_inc16(stat0);
         if (pop[1]) stat1 <= sat_inc16(stat1);
         stat_ovf <= sat_add8(stat_ovf, {1'b0, ovf_ev[0]} + {1'b0, ovf_ev[1]});
      end
   end
`endif
endmodule

// File: tb/tb_ej_sched.sv
// Directed self-checking bench for ej_sched (default DEPTH=4).
module tb_ej_sched;
   import ej_sched_pkg::*;
   localparam int W = `STEER_W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] c_ej0 = '0;
   logic [W-1:0] c_ej1 = '0;
   logic         out_ready = 1'b0;
   logic         ej_en0;
   logic         ej_en1;
   logic [W-1:0] out_flit;
   logic         out_valid;
   logic         ovf_err;
`ifdef EJ_SCHED_STATS_EN
   logic [15:0]  stat0;
   logic [15:0]  stat1;
   logic [7:0]   stat_ovf;
`endif
   int n_pass = 0;
   int n_total = 0;

   ej_sched #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .c_ej0(c_ej0), .c_ej1(c_ej1),
      .ej_en0(ej_en0), .ej_en1(ej_en1), .out_flit(out_flit),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef EJ_SCHED_STATS_EN
      .stat0(stat0), .stat1(stat1), .stat_ovf(stat_ovf),
`endif
      .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic [3:0] dest, input logic [7:0] pl);
      logic [W-1:0] f;
      f = '0;
      f[`VALID_F] = 1'b1;
      f[`DEST_F]  = dest;
      f[7:0]      = pl;
      return f;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      c_ej0 = '0;
      c_ej1 = '0;
      out_ready = 1'b0;
      rst_n = 1'b0;
      step;
      step;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      c_ej0 = '0;
      c_ej1 = '0;
      out_ready = 1'b0;
      rst_n = 1'b0;
      step;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
      else n_pass++;
      n_total++;
      if (out_flit !== '0) $display("FAIL reset_flit got %h want 0", out_flit);
      else n_pass++;
      n_total++;
      if ({ej_en0, ej_en1} !== 2'b11) $display("FAIL reset_en got %b%b want 11", ej_en0, ej_en1);
      else n_pass++;
      n_total++;
      if (ovf_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf_err);
      else n_pass++;
      rst_n = 1'b1;
      step;
   endtask

   task automatic test_single;
      logic [W-1:0] f;
      do_reset;
      f = mk(4'd3, 8'hA5);
      out_ready = 1'b1;
      c_ej0 = f;
      step;
      c_ej0 = '0;
      n_total++;
      if (out_valid !== 1'b1 || out_flit !== f)
         $display("FAIL single_out got v=%b %h want v=1 %h", out_valid, out_flit, f);
      else n_pass++;
      n_total++;
      if (ej_en0 !== 1'b1) $display("FAIL single_en0 got %b want 1", ej_en0);
      else n_pass++;
      step;
      n_total++;
      if (out_valid !== 1'b0 || out_flit !== '0)
         $display("FAIL single_after got v=%b %h want v=0 0", out_valid, out_flit);
      else n_pass++;
      n_total++;
      if (ej_en0 !== 1'b1) $display("FAIL single_en0_after got %b want 1", ej_en0);
      else n_pass++;
   endtask

   task automatic test_simultaneous;
      logic [W-1:0] fa, fb, fc, fd;
      do_reset;
      fa = mk(4'd1, 8'h11); fb = mk(4'd2, 8'h22);
      fc = mk(4'd3, 8'h33); fd = mk(4'd4, 8'h44);
      out_ready = 1'b1;
      c_ej0 = fa; c_ej1 = fb;
      step;
      c_ej0 = '0; c_ej1 = '0;
      n_total++;
      if (out_flit !== fa) $display("FAIL simul_first got %h want %h", out_flit, fa);
      else n_pass++;
      step;
      n_total++;
      if (out_flit !== fb) $display("FAIL simul_second got %h want %h", out_flit, fb);
      else n_pass++;
      step;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL simul_idle got %b want 0", out_valid);
      else n_pass++;
      // pointer should be back at channel 0
      c_ej0 = fc; c_ej1 = fd;
      step;
      c_ej0 = '0; c_ej1 = '0;
      n_total++;
      if (out_flit !== fc) $display("FAIL simul_ptr got %h want %h", out_flit, fc);
      else n_pass++;
      step;
      n_total++;
      if (out_flit !== fd) $display("FAIL simul_ptr2 got %h want %h", out_flit, fd);
      else n_pass++;
      step;
`ifdef EJ_SCHED_STATS_EN
      n_total++;
      if (stat0 !== 16'd2 || stat1 !== 16'd2)
         $display("FAIL simul_stats got %0d/%0d want 2/2", stat0, stat1);
      else n_pass++;
`endif
   endtask

   task automatic test_fairness;
      logic [W-1:0] q0[$];
      logic [W-1:0] q1[$];
      logic [W-1:0] exp_f;
      do_reset;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         c_ej0 = ej_en0 ? mk(4'd0, 8'(i)) : '0;
         c_ej1 = ej_en1 ? mk(4'd1, 8'(8'h10 + i)) : '0;
         if (ej_en0) q0.push_back(c_ej0);
         if (ej_en1) q1.push_back(c_ej1);
         step;
         exp_f = (i % 2 == 0) ? q0.pop_front() : q1.pop_front();
         n_total++;
         if (out_flit !== exp_f) $display("FAIL fair_%0d got %h want %h", i, out_flit, exp_f);
         else n_pass++;
      end
      c_ej0 = '0; c_ej1 = '0;
      for (int i = 0; i < 8; i++) step;
      n_total++;
      if (ovf_err !== 1'b0) $display("FAIL fair_ovf got %b want 0", ovf_err);
      else n_pass++;
   endtask

   task automatic test_backpressure;
      logic [W-1:0] p [3];
      do_reset;
      for (int i = 0; i < 3; i++) p[i] = mk(4'd5, 8'(8'h40 + i));
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c_ej0 = p[i];
         step;
         n_total++;
         if (ej_en0 !== (i < 2)) $display("FAIL bp_en0_%0d got %b want %b", i, ej_en0, (i < 2));
         else n_pass++;
      end
      c_ej0 = '0;
      for (int i = 0; i < 10; i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_flit !== p[0])
            $display("FAIL bp_stall_%0d got v=%b %h want v=1 %h", i, out_valid, out_flit, p[0]);
         else n_pass++;
         step;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (out_flit !== p[i]) $display("FAIL bp_drain_%0d got %h want %h", i, out_flit, p[i]);
         else n_pass++;
         step;
         if (i == 0) begin
            n_total++;
            if (ej_en0 !== 1'b1) $display("FAIL bp_en0_release got %b want 1", ej_en0);
            else n_pass++;
         end
      end
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_lock;
      logic [W-1:0] fx, fy, fz;
      do_reset;
      fx = mk(4'd6, 8'h61); fy = mk(4'd6, 8'h62); fz = mk(4'd7, 8'h71);
      out_ready = 1'b1;
      c_ej0 = fx;
      step;
      c_ej0 = '0;
      step;
      // pointer now favours channel 1; a stalled channel-0 grant must hold
      out_ready = 1'b0;
      c_ej0 = fy;
      step;
      c_ej0 = '0;
      c_ej1 = fz;
      step;
      c_ej1 = '0;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (out_flit !== fy) $display("FAIL lock_%0d got %h want %h", i, out_flit, fy);
         else n_pass++;
         step;
      end
      out_ready = 1'b1;
      step;
      n_total++;
      if (out_flit !== fz) $display("FAIL lock_next got %h want %h", out_flit, fz);
      else n_pass++;
      step;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL lock_empty got %b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_overflow;
      logic [W-1:0] p [5];
      do_reset;
      for (int i = 0; i < 5; i++) p[i] = mk(4'd8, 8'(8'h80 + i));
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         c_ej0 = p[i];
         step;
         if (i >= 3) begin
            n_total++;
            if (ovf_err !== (i == 4)) $display("FAIL ovf_flag_%0d got %b want %b", i, ovf_err, (i == 4));
            else n_pass++;
         end
      end
      c_ej0 = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_flit !== p[i])
            $display("FAIL ovf_drain_%0d got v=%b %h want v=1 %h", i, out_valid, out_flit, p[i]);
         else n_pass++;
         step;
      end
      n_total++;
      if (out_valid !== 1'b0 || ovf_err !== 1'b1)
         $display("FAIL ovf_end got v=%b ovf=%b want v=0 ovf=1", out_valid, ovf_err);
      else n_pass++;
`ifdef EJ_SCHED_STATS_EN
      n_total++;
      if (stat_ovf !== 8'd1) $display("FAIL ovf_stat got %0d want 1", stat_ovf);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_stall;
      do_reset;
      out_ready = 1'b0;
      c_ej0 = mk(4'd9, 8'h91);
      step;
      c_ej0 = mk(4'd9, 8'h92);
      step;
      c_ej0 = '0;
      n_total++;
      if (out_valid !== 1'b1 || ej_en0 !== 1'b1)
         $display("FAIL rst_pre got v=%b en=%b want v=1 en=1", out_valid, ej_en0);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || out_flit !== '0)
         $display("FAIL rst_async got v=%b %h want v=0 0", out_valid, out_flit);
      else n_pass++;
      n_total++;
      if ({ej_en0, ej_en1} !== 2'b11) $display("FAIL rst_en got %b%b want 11", ej_en0, ej_en1);
      else n_pass++;
      step;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step;
         n_total++;
         if (out_valid !== 1'b0) $display("FAIL rst_after_%0d got %b want 0", i, out_valid);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_simultaneous;
      test_fairness;
      test_backpressure;
      test_lock;
      test_overflow;
      test_reset_stall;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
